// File: rtl/trng_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : trng_pkg
//  Description : Shared types and constants for the TRNG control sequencer.
//                Holds the sequencer state encoding, the word width and the
//                stuck-at-ones pattern used by the health check.
//  Revision    : 1.0 - initial release
// ============================================================================
package trng_pkg;

    // Number of sampler bits that make up one random word
    localparam int unsigned TRNG_WORD_BITS = 32;

    // A word of all ones means the sampler output is stuck high
    localparam logic [31:0] TRNG_STUCK_ONES = 32'hFFFF_FFFF;

    // Sequencer states, explicit 3-bit encoding
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WARMUP  = 3'd1,
        ST_CLEAR   = 3'd2,
        ST_SAMPLE  = 3'd3,
        ST_SETTLE  = 3'd4,
        ST_CAPTURE = 3'd5,
        ST_STALL   = 3'd6
    } trng_ctrl_state_t;

endpackage : trng_pkg
`default_nettype wire

// File: rtl/trng_word_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : trng_word_fifo
//  Description : First-word-fall-through buffer for accepted random words.
//                data_out always shows the head entry while empty is low.
//                Ports: clk, rst (sync, active-high), flush (empties buffer,
//                drops a same-cycle push), push/data_in, pop/data_out,
//                empty, full, level (occupancy).
//  Revision    : 1.0 - initial release
// ============================================================================
module trng_word_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           data_in,
    input  logic                       pop,
    output logic [WIDTH-1:0]           data_out,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int unsigned c_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_level;

    logic w_do_pop;
    logic w_do_push;

    assign empty    = (r_level == '0);
    assign full     = (r_level == (c_AW+1)'(DEPTH));
    assign level    = r_level;
    assign data_out = r_mem[r_rd_ptr];

    // A pop on an empty buffer is ignored. When full, a push is still
    // accepted alongside a pop because the head slot frees at the same edge.
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= data_in;
                r_wr_ptr        <= r_wr_ptr + c_AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + (c_AW+1)'(1);
                2'b01:   r_level <= r_level - (c_AW+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule : trng_word_fifo
`default_nettype wire

// File: rtl/trng_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : trng_ctrl
//  Description : Sequencer driving the TRNG sampler's enable, sample_trig
//                and clear lines. Warms the oscillators up, issues paced
//                sample triggers, collects 32-bit words, health-checks them
//                and buffers accepted words for the register front end.
//                Ports: clk, rst; ctrl_enable, flush, status_clr (control);
//                trng_enable/trng_sample_trig/trng_clear (to sampler);
//                trng_random/trng_count (from sampler); rnd_data/rnd_valid/
//                rnd_ready/fifo_level (word stream); warm, busy,
//                health_fail_cnt, rep_fail, seq_err (status).
//  Revision    : 1.0 - initial release
// ============================================================================
module trng_ctrl
    import trng_pkg::*;
#(
    parameter int unsigned WARMUP_CYCLES = 1024,
    parameter int unsigned SAMPLE_DIV    = 16,
    parameter int unsigned FIFO_DEPTH    = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ctrl_enable,
    input  logic                          flush,
    input  logic                          status_clr,
    output logic                          trng_enable,
    output logic                          trng_sample_trig,
    output logic                          trng_clear,
    input  logic [31:0]                   trng_random,
    input  logic [31:0]                   trng_count,
    output logic [31:0]                   rnd_data,
    output logic                          rnd_valid,
    input  logic                          rnd_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          warm,
    output logic                          busy,
    output logic [15:0]                   health_fail_cnt,
    output logic                          rep_fail,
    output logic                          seq_err
);

    localparam int unsigned c_WARM_W = $clog2(WARMUP_CYCLES + 1);
    localparam int unsigned c_DIV_W  = $clog2(SAMPLE_DIV);
    localparam int unsigned c_BIT_W  = $clog2(TRNG_WORD_BITS + 1);

    localparam logic [c_WARM_W-1:0] c_WARM_LOAD = c_WARM_W'(WARMUP_CYCLES - 1);
    localparam logic [c_DIV_W-1:0]  c_DIV_LAST  = c_DIV_W'(SAMPLE_DIV - 1);
    localparam logic [c_BIT_W-1:0]  c_LAST_BIT  = c_BIT_W'(TRNG_WORD_BITS - 1);

    trng_ctrl_state_t    r_state;
    logic [c_WARM_W-1:0] r_warm_cnt;
    logic [c_DIV_W-1:0]  r_div_cnt;
    logic [c_BIT_W-1:0]  r_bit_cnt;
    logic                r_warm;
    logic [31:0]         r_last_word;
    logic [15:0]         r_fail_cnt;
    logic                r_rep_fail;
    logic                r_seq_err;

    logic w_trig;
    logic w_capture;
    logic w_count_ok;
    logic w_repeat;
    logic w_accept;
    logic w_rep_hit;
    logic w_seq_hit;
    logic w_fifo_full;
    logic w_fifo_empty;

    // Sampler control lines decode straight from the state register
    assign w_trig           = (r_state == ST_SAMPLE) && (r_div_cnt == c_DIV_LAST);
    assign trng_enable      = (r_state != ST_IDLE);
    assign busy             = (r_state != ST_IDLE);
    assign trng_clear       = (r_state == ST_CLEAR);
    assign trng_sample_trig = w_trig;
    assign warm             = r_warm;

    // Health check; a dropped ctrl_enable abandons the word being captured
    assign w_capture  = (r_state == ST_CAPTURE) && ctrl_enable;
    assign w_count_ok = (trng_count == 32'(TRNG_WORD_BITS));
    assign w_repeat   = (trng_random == 32'h0) ||
                        (trng_random == TRNG_STUCK_ONES) ||
                        (trng_random == r_last_word);
    assign w_seq_hit  = w_capture & ~w_count_ok;
    assign w_rep_hit  = w_capture &  w_count_ok &  w_repeat;
    assign w_accept   = w_capture &  w_count_ok & ~w_repeat;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_warm_cnt <= '0;
            r_div_cnt  <= '0;
            r_bit_cnt  <= '0;
            r_warm     <= 1'b0;
        end else if (!ctrl_enable) begin
            r_state    <= ST_IDLE;
            r_warm_cnt <= '0;
            r_div_cnt  <= '0;
            r_bit_cnt  <= '0;
            r_warm     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_warm_cnt <= c_WARM_LOAD;
                    r_state    <= ST_WARMUP;
                end
                ST_WARMUP: begin
                    if (r_warm_cnt == '0) begin
                        r_warm  <= 1'b1;
                        r_state <= ST_CLEAR;
                    end else begin
                        r_warm_cnt <= r_warm_cnt - c_WARM_W'(1);
                    end
                end
                ST_CLEAR: begin
                    r_div_cnt <= '0;
                    r_bit_cnt <= '0;
                    // Only start a word when its result is sure to fit
                    r_state   <= w_fifo_full ? ST_STALL : ST_SAMPLE;
                end
                ST_SAMPLE: begin
                    if (w_trig) begin
                        r_div_cnt <= '0;
                        r_bit_cnt <= r_bit_cnt + c_BIT_W'(1);
                        if (r_bit_cnt == c_LAST_BIT) begin
                            r_state <= ST_SETTLE;
                        end
                    end else begin
                        r_div_cnt <= r_div_cnt + c_DIV_W'(1);
                    end
                end
                ST_SETTLE:  r_state <= ST_CAPTURE;
                ST_CAPTURE: r_state <= ST_CLEAR;
                ST_STALL: begin
                    if (!w_fifo_full) begin
                        r_state <= ST_SAMPLE;
                    end
                end
                default:    r_state <= ST_IDLE;
            endcase
        end
    end

    // Status: a clear in the same cycle as a new fail wins
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_word <= '0;
            r_fail_cnt  <= '0;
            r_rep_fail  <= 1'b0;
            r_seq_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_last_word <= trng_random;
            end
            if (status_clr) begin
                r_fail_cnt <= '0;
                r_rep_fail <= 1'b0;
                r_seq_err  <= 1'b0;
            end else begin
                if (w_seq_hit) begin
                    r_seq_err <= 1'b1;
                end
                if (w_rep_hit) begin
                    r_rep_fail <= 1'b1;
                    if (r_fail_cnt != 16'hFFFF) begin
                        r_fail_cnt <= r_fail_cnt + 16'd1;
                    end
                end
            end
        end
    end

    assign health_fail_cnt = r_fail_cnt;
    assign rep_fail        = r_rep_fail;
    assign seq_err         = r_seq_err;

    trng_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (TRNG_WORD_BITS)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .push     (w_accept),
        .data_in  (trng_random),
        .pop      (rnd_ready),
        .data_out (rnd_data),
        .empty    (w_fifo_empty),
        .full     (w_fifo_full),
        .level    (fifo_level)
    );

    assign rnd_valid = ~w_fifo_empty;

endmodule : trng_ctrl
`default_nettype wire

// File: tb/tb_trng_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_trng_ctrl
//  Description : Self-checking bench for trng_ctrl with a behavioural
//                sampler. Each planned sampler word carries its expected
//                fate; accepted words are queued when the word is started
//                and compared against the stream as it is popped.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_trng_ctrl;

    localparam int unsigned W = 8;
    localparam int unsigned D = 4;
    localparam int unsigned N_PLAN = 13;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ctrl_enable = 1'b0;
    logic        flush = 1'b0;
    logic        status_clr = 1'b0;
    logic        trng_enable;
    logic        trng_sample_trig;
    logic        trng_clear;
    logic [31:0] trng_random;
    logic [31:0] trng_count;
    logic [31:0] rnd_data;
    logic        rnd_valid;
    logic        rnd_ready = 1'b0;
    logic [2:0]  fifo_level;
    logic        warm;
    logic        busy;
    logic [15:0] health_fail_cnt;
    logic        rep_fail;
    logic        seq_err;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_q[$];

    // Planned sampler output: word, short-count flag, expected acceptance
    logic [31:0] plan_word [N_PLAN] = '{32'hDEADBEEF, 32'hDEADBEEF, 32'h00000000,
                                        32'hFFFFFFFF, 32'h12345678, 32'hA5A5A5A5,
                                        32'h0F0F0F0F, 32'h13579BDF, 32'hCAFEF00D,
                                        32'h11223344, 32'h77777777, 32'h55AA33CC,
                                        32'h55AA33CC};
    logic        plan_short [N_PLAN] = '{0,0,0,0,0,0,0,0,1,0,0,0,0};
    logic        plan_acc   [N_PLAN] = '{1,0,0,0,1,1,1,1,0,1,0,1,0};

    always #5 clk = ~clk;

    trng_ctrl #(
        .WARMUP_CYCLES (W),
        .SAMPLE_DIV    (D),
        .FIFO_DEPTH    (4)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .ctrl_enable      (ctrl_enable),
        .flush            (flush),
        .status_clr       (status_clr),
        .trng_enable      (trng_enable),
        .trng_sample_trig (trng_sample_trig),
        .trng_clear       (trng_clear),
        .trng_random      (trng_random),
        .trng_count       (trng_count),
        .rnd_data         (rnd_data),
        .rnd_valid        (rnd_valid),
        .rnd_ready        (rnd_ready),
        .fifo_level       (fifo_level),
        .warm             (warm),
        .busy             (busy),
        .health_fail_cnt  (health_fail_cnt),
        .rep_fail         (rep_fail),
        .seq_err          (seq_err)
    );

    // Behavioural sampler: clear loads the next planned word, each trigger
    // shifts in one bit of it MSB first and bumps the sample count.
    logic [31:0] s_rand;
    logic [31:0] s_cnt;
    logic [31:0] s_word;
    logic        s_short;
    int          plan_idx;

    always @(posedge clk) begin
        if (rst) begin
            s_rand   <= '0;
            s_cnt    <= '0;
            s_word   <= '0;
            s_short  <= 1'b0;
            plan_idx <= 0;
        end else if (trng_clear) begin
            s_rand <= '0;
            s_cnt  <= '0;
            if (plan_idx < int'(N_PLAN)) begin
                s_word  <= plan_word[plan_idx];
                s_short <= plan_short[plan_idx];
                if (plan_acc[plan_idx]) exp_q.push_back(plan_word[plan_idx]);
            end else begin
                s_word  <= '0;
                s_short <= 1'b0;
            end
            plan_idx <= plan_idx + 1;
        end else if (trng_sample_trig) begin
            s_rand <= {s_rand[30:0], s_word[5'(31 - s_cnt)]};
            s_cnt  <= s_cnt + 1;
        end
    end

    assign trng_random = s_rand;
    assign trng_count  = s_short ? (s_cnt - 32'd1) : s_cnt;

    // Scoreboard monitor: checks every word that leaves the buffer
    always @(negedge clk) begin
        #2;
        if (!rst && rnd_valid && rnd_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL pop_unexpected: got %h, expected no word", rnd_data);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (rnd_data !== e) begin
                    bad++;
                    $display("FAIL pop_data: got %h, expected %h", rnd_data, e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_clears(input int k);
        for (int c = 0; c < k; c++) begin
            int n;
            n = 0;
            do begin
                tick();
                n++;
            end while (!trng_clear && n < 1000);
            if (!trng_clear) begin
                total++;
                bad++;
                $display("FAIL wait_clear: got no clear after %0d cycles, expected one", n);
            end
        end
    endtask

    task automatic pulse_status_clr();
        status_clr = 1'b1;
        tick();
        status_clr = 1'b0;
    endtask

    initial begin
        int n;
        int clear_n;
        int trig1_n;
        int trig2_n;
        int valid_n;
        int trigs;

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        tick();
        chk("rst_enable", 32'(trng_enable), 0);
        chk("rst_busy",   32'(busy), 0);
        chk("rst_valid",  32'(rnd_valid), 0);
        chk("rst_level",  32'(fifo_level), 0);
        chk("rst_fails",  32'(health_fail_cnt), 0);
        chk("rst_warm",   32'(warm), 0);

        // First word timing: clear after W cycles, trigs D apart,
        // first word visible W+1+32*D+3 edges after enable
        ctrl_enable = 1'b1;
        clear_n = 0; trig1_n = 0; trig2_n = 0; valid_n = 0;
        for (n = 1; n <= 400; n++) begin
            tick();
            if (trng_clear && clear_n == 0) clear_n = n;
            if (trng_sample_trig) begin
                if (trig1_n == 0) trig1_n = n;
                else if (trig2_n == 0) trig2_n = n;
            end
            if (rnd_valid) begin
                valid_n = n;
                break;
            end
        end
        chk("clear_time",    32'(clear_n), W + 1);
        chk("first_trig",    32'(trig1_n), W + 1 + D);
        chk("trig_interval", 32'(trig2_n - trig1_n), D);
        chk("first_valid",   32'(valid_n), W + 1 + 32 * D + 3);
        chk("warm_set",      32'(warm), 1);
        chk("first_data",    rnd_data, 32'hDEADBEEF);

        // Repeated word rejected
        wait_clears(1);
        chk("rep_cnt1",   32'(health_fail_cnt), 1);
        chk("rep_flag1",  32'(rep_fail), 1);
        chk("rep_level1", 32'(fifo_level), 1);
        chk("rep_seq1",   32'(seq_err), 0);
        pulse_status_clr();
        chk("clr_cnt1",   32'(health_fail_cnt), 0);
        chk("clr_flag1",  32'(rep_fail), 0);

        // All-zero and all-one words rejected
        wait_clears(2);
        chk("stuck_cnt",   32'(health_fail_cnt), 2);
        chk("stuck_flag",  32'(rep_fail), 1);
        chk("stuck_level", 32'(fifo_level), 1);
        pulse_status_clr();
        chk("clr_cnt2",    32'(health_fail_cnt), 0);
        chk("clr_flag2",   32'(rep_fail), 0);

        // Fill the buffer, then the sequencer stalls without triggering
        wait_clears(3);
        chk("full_level", 32'(fifo_level), 4);
        trigs = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (trng_sample_trig) trigs++;
        end
        chk("stall_trigs",  32'(trigs), 0);
        chk("stall_busy",   32'(busy), 1);
        chk("stall_enable", 32'(trng_enable), 1);

        // One pop frees a slot; sampling resumes the next cycle
        rnd_ready = 1'b1;
        tick();
        rnd_ready = 1'b0;
        chk("pop_level", 32'(fifo_level), 3);
        n = 1;
        while (!trng_sample_trig && n < 50) begin
            tick();
            n++;
        end
        chk("resume_trig", 32'(n), D + 1);
        rnd_ready = 1'b1;

        // Short sample count: sequence error, nothing pushed
        wait_clears(2);
        chk("seq_flag",  32'(seq_err), 1);
        chk("seq_fails", 32'(health_fail_cnt), 0);
        chk("seq_rep",   32'(rep_fail), 0);
        rnd_ready = 1'b0;

        // Next word accepted, then abort the following word at bit 10
        wait_clears(1);
        chk("keep_level", 32'(fifo_level), 1);
        trigs = 0;
        n = 0;
        while (trigs < 10 && n < 500) begin
            tick();
            n++;
            if (trng_sample_trig) trigs++;
        end
        chk("abort_trigs", 32'(trigs), 10);
        tick();
        ctrl_enable = 1'b0;
        tick();
        chk("abort_busy",   32'(busy), 0);
        chk("abort_enable", 32'(trng_enable), 0);
        chk("abort_warm",   32'(warm), 0);
        chk("abort_trig",   32'(trng_sample_trig), 0);
        chk("abort_level",  32'(fifo_level), 1);
        chk("abort_head",   rnd_data, 32'h11223344);

        // Re-enable repeats the full warm-up
        repeat (3) tick();
        ctrl_enable = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!trng_clear && n < 100);
        chk("rewarm_clear", 32'(n), W + 1);
        wait_clears(1);
        chk("rewarm_level", 32'(fifo_level), 2);

        // Flush empties the buffer but keeps the last accepted word
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_level", 32'(fifo_level), 0);
        chk("flush_valid", 32'(rnd_valid), 0);
        exp_q.delete();
        wait_clears(1);
        chk("post_flush_rep",   32'(health_fail_cnt), 1);
        chk("post_flush_flag",  32'(rep_fail), 1);
        chk("post_flush_level", 32'(fifo_level), 0);
        chk("queue_empty",      32'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got no end of test, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_trng_ctrl
`default_nettype wire

// File: doc/trng_ctrl.md
Name: trng_ctrl

Overview:
Sequencer that owns the TRNG sampler's control inputs: enable, sample_trig and clear.
- Runs a warm-up period, then issues paced sample triggers and collects one 32-bit word per 32 samples.
- Health-checks each word and buffers accepted words in a small FIFO for the AXI-lite register front end (valid/ready).
- Sits between the sampler instance and the HSM register block.

Parameters:
WARMUP_CYCLES, 1024, clk cycles the oscillators run before the first sample (>=1)
SAMPLE_DIV, 16, clk cycles between consecutive sample_trig pulses (>=2, keeps trig low >=1 cycle between pulses)
FIFO_DEPTH, 4, accepted-word buffer depth (power of 2, >=2)

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high, single clock domain
ctrl_enable  in  1  level; 1 = run generator
flush  in  1  pulse; empties FIFO
status_clr  in  1  pulse; clears health_fail_cnt, rep_fail, seq_err
trng_enable  out  1  to sampler enable
trng_sample_trig  out  1  to sampler sample_trig (one-cycle pulses)
trng_clear  out  1  to sampler clear (one-cycle pulse)
trng_random  in  32  from sampler random_out
trng_count  in  32  from sampler sample_count
rnd_data  out  32  FIFO head word
rnd_valid  out  1  FIFO non-empty
rnd_ready  in  1  pop when rnd_valid & rnd_ready
fifo_level  out  $clog2(FIFO_DEPTH)+1  occupancy
warm  out  1  warm-up complete since last enable
busy  out  1  state != IDLE
health_fail_cnt  out  16  rejected words; saturates at 16'hFFFF
rep_fail  out  1  sticky; repetition/stuck reject seen
seq_err  out  1  sticky; sampler count mismatch seen

Behaviour:
- Reset: all outputs and internal registers 0, FIFO empty, state IDLE. Reset mid-operation aborts the word immediately; FIFO contents are lost.
- FSM states: IDLE, WARMUP, CLEAR, SAMPLE, SETTLE, CAPTURE, STALL.
- IDLE: trng_enable=0. ctrl_enable=1 -> WARMUP and load warm counter.
- WARMUP: trng_enable=1 for WARMUP_CYCLES cycles, then warm=1 -> CLEAR.
- CLEAR: trng_clear=1 for exactly one cycle; bit_cnt=0, div_cnt=0.
  - FIFO full -> STALL.
  - Otherwise -> SAMPLE.
- SAMPLE: div_cnt counts 0..SAMPLE_DIV-1. On div_cnt==SAMPLE_DIV-1:
  - trng_sample_trig=1 for that cycle only; bit_cnt++.
  - When bit_cnt reaches 32 -> SETTLE.
- SETTLE: one cycle so the sampler's last shift is registered -> CAPTURE.
- CAPTURE (one cycle) checks, in priority order:
  - trng_count != 32: seq_err=1, word discarded.
  - trng_random == 0, == 32'hFFFFFFFF, or == last accepted word: rep_fail=1, health_fail_cnt++ (saturating), word discarded.
  - Otherwise: push to FIFO and update last accepted word.
  - Always -> CLEAR.
- STALL: trng_enable stays 1, no triggers. When FIFO not full -> SAMPLE.
- FIFO space is guaranteed at CAPTURE, because a word only starts when the FIFO is not full.
- Throughput: one word per 32*SAMPLE_DIV+3 cycles; the first word completes WARMUP_CYCLES+1+32*SAMPLE_DIV+2 cycles after enable.
- ctrl_enable=0 in any state:
  - Next cycle: IDLE, trng_enable=0, trig/clear low, partial word and warm discarded.
  - FIFO contents and status are retained.
  - Re-enable repeats the full warm-up.
- FIFO is first-word-fall-through; rnd_data is valid whenever rnd_valid=1.
  - Push and pop in the same cycle: both take effect, level unchanged.
  - Pop when empty is ignored.
- flush: FIFO empty next cycle. A push in the same cycle is dropped; the last accepted word is kept.
- status_clr with a simultaneous fail: the clear wins for that cycle and the new fail is lost. This is documented behaviour.

Decomposition:
- Package trng_pkg holds: state enum trng_ctrl_state_t, constant TRNG_WORD_BITS=32, constant TRNG_STUCK_ONES=32'hFFFFFFFF.
- One sub-module trng_word_fifo: parameterised depth, FWFT, synchronous active-high reset plus flush; ports push/data_in/pop/data_out/empty/full/level.

Test Plan:
- Reset, then ctrl_enable=1 with WARMUP_CYCLES=8, SAMPLE_DIV=4, behavioural sampler -> trig pulses 4 cycles apart, trng_clear pulse after warm-up, first rnd_valid at cycle 8+1+128+2 (+1 FIFO push).
- Sampler model emits 32'hDEADBEEF then 32'hDEADBEEF -> first word accepted, second rejected; health_fail_cnt=1, rep_fail=1, fifo_level=1.
- Model emits 32'h0 and 32'hFFFFFFFF -> both rejected, health_fail_cnt=2; status_clr -> counters 0.
- rnd_ready=0 with FIFO_DEPTH=4 -> after 4 accepted words state STALL and no triggers; one pop -> SAMPLE resumes within 1 cycle.
- Model returns trng_count=31 at CAPTURE -> seq_err=1, no push.
- ctrl_enable dropped mid-SAMPLE at bit_cnt=10 -> next cycle IDLE, trng_enable=0, FIFO retained; re-enable -> full warm-up, then bit_cnt restarts at 0.
